sram_mmio_bus: RTL
==================

Name: sram_mmio_bus

Overview:
- Memory-side slave that directly consumes the RV32I core's single-master bus (addr, wdata, we, re, be) and returns read data.
- Decodes each access into one of two regions: an on-chip word-addressed SRAM, or a small memory-mapped register bank (GPIO output, bus-error status, optional timer).
- Serves both instruction fetches and data accesses.
- Read data is registered, giving one-cycle read latency.

Parameters:
- DEPTH, 1024, number of 32-bit SRAM words; must be a power of two.
- AW, 10, SRAM word-index width; must equal log2(DEPTH).
- GPIO_W, 8, width of the gpio_out register.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- addr  in  32  byte address from core; addr[1:0] ignored, all accesses word-aligned
- wdata  in  32  write data
- rdata  out  32  registered read data
- we  in  1  write strobe, single cycle per access
- re  in  1  read strobe, single cycle per access
- be  in  4  byte-lane enables for writes; be[0] maps to wdata[7:0]
- gpio_out  out  GPIO_W  GPIO output register
- bus_err  out  1  sticky access-error flag
- timer_irq  out  1  timer interrupt, level

Behaviour:
- Reset (rst_n low, asynchronous):
  - rdata = 0, gpio_out = 0, bus_err = 0, timer_irq = 0, all timer registers = 0.
  - SRAM contents are not reset.
  - Reset asserted mid-access aborts that access: no write commits and rdata goes to 0.
- Decode:
  - addr[31] = 0 selects SRAM. Word index = addr[AW+1:2].
  - SRAM access is out of range if addr[30:AW+2] is nonzero.
  - addr[31] = 1 selects MMIO. Offset = addr[7:0]; addr[30:8] is ignored.
- MMIO register map:
  - 0x00 GPIO_OUT: RW. Low GPIO_W bits are writable; reads zero-extend.
  - 0x04 STATUS: bit0 = bus_err. Writing 1 to bit0 clears it; other bits read 0.
  - 0x08 TIMER_COUNT, 0x0C TIMER_CMP, 0x10 TIMER_CTRL: timer registers, present only with the optional feature.
  - Any other offset is unmapped.
- Write (we = 1 sampled at a clock edge):
  - Each byte lane with be[i] = 1 is updated in the same edge.
  - be = 0000 is a no-op and is not an error.
  - MMIO registers honour be per byte as well.
- Read (re = 1 sampled at edge N):
  - rdata is updated at edge N and holds that value until the next read.
  - Latency is 1 cycle. rdata is never updated when re = 0.
- we and re both high: the write is performed, the read is ignored, and rdata holds its previous value.
- Out-of-range SRAM access or unmapped MMIO offset:
  - Write is dropped; read returns 0.
  - bus_err is set at that edge.
- bus_err priority: a set in the same cycle as a STATUS clear wins, so bus_err stays 1.
- Read-before-write: a read of a word written in an earlier cycle returns the new data.

Optional Feature:
- Macro: MMIO_TIMER_EN.
- When defined, the timer registers are implemented:
  - TIMER_COUNT increments by 1 every cycle while TIMER_CTRL bit0 (enable) = 1, wrapping 0xFFFFFFFF to 0.
  - A bus write to TIMER_COUNT takes priority over the increment in the same cycle.
  - TIMER_CTRL bit1 (pending) is set on the edge where enable = 1 and TIMER_COUNT == TIMER_CMP.
  - Writing 1 to TIMER_CTRL bit1 clears pending; a set in the same cycle wins over the clear.
  - timer_irq = pending.
- When undefined:
  - Offsets 0x08, 0x0C and 0x10 are unmapped and set bus_err.
  - timer_irq is tied to 0.

Test Plan:
- Write 0xDEADBEEF to addr 0x00000010 with be = 1111, then re to 0x10 → rdata = 0xDEADBEEF one cycle after re.
- Write 0x000000AA to 0x10 with be = 0001 over that word → read gives 0xDEADBEAA; be = 0000 write leaves it unchanged and bus_err stays 0.
- Write 0x5A to 0x80000000 → gpio_out = 0x5A. Read 0x40000000 → rdata = 0 and bus_err = 1. Write 1 to 0x80000004 → bus_err = 0.
- Simultaneous we + re to 0x20 with prior rdata = 0x1234 → rdata stays 0x1234 and memory[0x20] is updated.
- MMIO_TIMER_EN defined: write CMP = 5, CTRL = 1 → timer_irq rises on the edge where COUNT == 5. Write CTRL = 3 → irq clears. COUNT = 0xFFFFFFFF wraps to 0.
- Assert rst_n low during a write cycle → write not committed; all outputs 0 immediately (asynchronously).

Source files
------------

// File: rtl/sram_mmio_bus.sv
// Bus slave for the RV32I core: word-addressed on-chip SRAM plus a small MMIO register bank.
// Optional timer registers are built only when MMIO_TIMER_EN is defined.
module sram_mmio_bus #(
    parameter int DEPTH  = 1024,
    parameter int AW     = 10,
    parameter int GPIO_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic              we,
    input  logic              re,
    input  logic [3:0]        be,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              bus_err,
    output logic              timer_irq
);

    localparam logic [7:0] OFF_GPIO   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_COUNT  = 8'h08;
    localparam logic [7:0] OFF_CMP    = 8'h0C;
    localparam logic [7:0] OFF_CTRL   = 8'h10;

    logic [31:0] mem [DEPTH];

    logic          sel_sram;
    logic          sram_oor;
    logic [AW-1:0] idx;
    logic [7:0]    off;
    logic          hit_gpio;
    logic          hit_status;
    logic          hit_count;
    logic          hit_cmp;
    logic          hit_ctrl;
    logic          mmio_mapped;
    logic          bad;
    logic          rd;
    logic          sram_wr;
    logic [31:0]   rd_val;
    logic [GPIO_W-1:0] gpio_next;
    logic          unused_addr;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    assign sel_sram    = ~addr[31];
    assign sram_oor    = |addr[30:AW+2];
    assign idx         = addr[AW+1:2];
    assign off         = addr[7:0];
    assign unused_addr = ^addr[1:0];

    assign hit_gpio   = addr[31] && (off == OFF_GPIO);
    assign hit_status = addr[31] && (off == OFF_STATUS);
`ifdef MMIO_TIMER_EN
    assign hit_count  = addr[31] && (off == OFF_COUNT);
    assign hit_cmp    = addr[31] && (off == OFF_CMP);
    assign hit_ctrl   = addr[31] && (off == OFF_CTRL);
`else
    assign hit_count  = 1'b0;
    assign hit_cmp    = 1'b0;
    assign hit_ctrl   = 1'b0;
`endif
    assign mmio_mapped = hit_gpio | hit_status | hit_count | hit_cmp | hit_ctrl;

    // A simultaneous write wins, so the read strobe only counts when we is low.
    assign bad     = (we | re) & (sel_sram ? sram_oor : ~mmio_mapped);
    assign rd      = re & ~we;
    assign sram_wr = we & sel_sram & ~sram_oor;

    // Gated by rst_n so a reset overlapping the write edge aborts the commit.
    always_ff @(posedge clk) begin
        if (rst_n && sram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

`ifdef MMIO_TIMER_EN
    logic [31:0] timer_count;
    logic [31:0] timer_cmp;
    logic        timer_en;
    logic        timer_pend;
    logic        timer_hit;
    logic        pend_clr;

    assign timer_hit = timer_en && (timer_count == timer_cmp);
    assign pend_clr  = we && hit_ctrl && be[0] && wdata[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_count <= '0;
            timer_cmp   <= '0;
            timer_en    <= 1'b0;
            timer_pend  <= 1'b0;
        end else begin
            if (we && hit_count) begin
                timer_count <= merge_bytes(timer_count, wdata, be);
            end else if (timer_en) begin
                timer_count <= timer_count + 32'd1;
            end
            if (we && hit_cmp) begin
                timer_cmp <= merge_bytes(timer_cmp, wdata, be);
            end
            if (we && hit_ctrl && be[0]) begin
                timer_en <= wdata[0];
            end
            timer_pend <= timer_hit | (timer_pend & ~pend_clr);
        end
    end

    assign timer_irq = timer_pend;
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        if (!bad) begin
            if (sel_sram) begin
                rd_val = mem[idx];
            end else if (hit_gpio) begin
                rd_val[GPIO_W-1:0] = gpio_out;
            end else if (hit_status) begin
                rd_val[0] = bus_err;
            end
`ifdef MMIO_TIMER_EN
            else if (hit_count) begin
                rd_val = timer_count;
            end else if (hit_cmp) begin
                rd_val = timer_cmp;
            end else if (hit_ctrl) begin
                rd_val[1:0] = {timer_pend, timer_en};
            end
`endif
        end
    end

    always_comb begin
        gpio_next = gpio_out;
        for (int i = 0; i < GPIO_W; i++) begin
            if (be[i/8]) gpio_next[i] = wdata[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata    <= '0;
            gpio_out <= '0;
            bus_err  <= 1'b0;
        end else begin
            if (rd) begin
                rdata <= rd_val;
            end
            if (we && hit_gpio) begin
                gpio_out <= gpio_next;
            end
            // An error in the same cycle as a STATUS clear keeps the flag set.
            if (bad) begin
                bus_err <= 1'b1;
            end else if (we && hit_status && be[0] && wdata[0]) begin
                bus_err <= 1'b0;
            end
        end
    end

endmodule
